aq_fadd_double_align: RTL and testbench

- Pre-add alignment pipeline for the double-precision FP adder; feeds the add/sub datapath that precedes the rounding stage.
- Unpacks two IEEE-754 double operands, orders them by magnitude, right-shifts the smaller significand by the exponent difference, and folds shifted-out bits into a sticky bit.
- Delivers guard/round/sticky-extended significands in the 56-bit format the downstream adder and rounder consume.
- Two-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/aq_fadd_double_align.sv | 184 ++++++++++++++++++
 tb/tb_aq_fadd_double_align.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_fadd_double_align.sv
// ============================================================================
//  Module   : aq_fadd_double_align
//  Purpose  : Pre-add alignment for the double-precision FP adder. Unpacks
//             two operands, orders them by magnitude, right-shifts the smaller
//             significand by the exponent difference and folds the shifted-out
//             bits into a sticky bit. Two-stage valid/ready pipeline.
//  Options  : AQ_FADD_ALIGN_DENORM_EN - keep denormal fractions (gradual
//             underflow); when undefined, denormals are flushed to zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aq_fadd_double_align #(
    parameter int SHIFT_SAT = 56
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        pipe_flush,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic        src0_sign,
    input  logic [10:0] src0_exp,
    input  logic [51:0] src0_frac,
    input  logic        src1_sign,
    input  logic [10:0] src1_exp,
    input  logic [51:0] src1_frac,
    input  logic        op_sub,
    input  logic [2:0]  rm,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [55:0] out_big_mant,
    output logic [55:0] out_sml_mant,
    output logic [10:0] out_exp,
    output logic        out_act_s,
    output logic        out_act_sub,
    output logic        out_swap,
    output logic        out_shift_sat,
    output logic [2:0]  out_rm
);

    localparam logic [11:0] SAT_AMT = 12'(SHIFT_SAT);

    // ------------------------------------------------------------------
    // Operand unpack (combinational, ahead of stage 1)
    // ------------------------------------------------------------------
    logic [51:0] frac0, frac1;
    logic        hid0, hid1;
    logic [10:0] eexp0, eexp1;
    logic        src1_esign, act_sub_d, swap_d, act_s_d;
    logic [11:0] diff_d;

`ifdef AQ_FADD_ALIGN_DENORM_EN
    assign frac0 = src0_frac;
    assign frac1 = src1_frac;
`else
    // Denormals become signed zeros: fraction dropped, sign kept.
    assign frac0 = (src0_exp == 11'd0) ? 52'd0 : src0_frac;
    assign frac1 = (src1_exp == 11'd0) ? 52'd0 : src1_frac;
`endif

    assign hid0  = (src0_exp != 11'd0);
    assign hid1  = (src1_exp != 11'd0);
    // Exponent 0 behaves as exponent 1 (denormal scale) for alignment.
    assign eexp0 = hid0 ? src0_exp : 11'd1;
    assign eexp1 = hid1 ? src1_exp : 11'd1;

    assign src1_esign = src1_sign ^ op_sub;
    assign act_sub_d  = src0_sign ^ src1_esign;
    assign swap_d     = (eexp1 > eexp0) || ((eexp1 == eexp0) && (frac1 > frac0));
    assign act_s_d    = swap_d ? src1_esign : src0_sign;
    assign diff_d     = swap_d ? ({1'b0, eexp1} - {1'b0, eexp0})
                               : ({1'b0, eexp0} - {1'b0, eexp1});

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;
    logic s1_adv, out_fire, accept;

    assign out_fire = s2_vld_q && out_rdy;
    assign s1_adv   = s1_vld_q && (!s2_vld_q || out_rdy);
    assign in_rdy   = !s1_vld_q || s1_adv;
    assign accept   = in_vld && in_rdy;
    assign out_vld  = s2_vld_q;

    // Valid next-state: flush wins over accept/advance.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        if (pipe_flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end else begin
            if (accept)      s1_vld_d = 1'b1;
            else if (s1_adv) s1_vld_d = 1'b0;
            if (s1_adv)        s2_vld_d = 1'b1;
            else if (out_fire) s2_vld_d = 1'b0;
        end
    end

    // Valid registers.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: ordered operands and exponent difference
    // ------------------------------------------------------------------
    logic [52:0] s1_big_q, s1_sml_q;
    logic [10:0] s1_exp_q;
    logic [11:0] s1_diff_q;
    logic        s1_act_s_q, s1_act_sub_q, s1_swap_q;
    logic [2:0]  s1_rm_q;

    // Capture the magnitude-ordered operand pair on accept.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            s1_big_q     <= '0;
            s1_sml_q     <= '0;
            s1_exp_q     <= '0;
            s1_diff_q    <= '0;
            s1_act_s_q   <= 1'b0;
            s1_act_sub_q <= 1'b0;
            s1_swap_q    <= 1'b0;
            s1_rm_q      <= '0;
        end else if (accept) begin
            s1_big_q     <= swap_d ? {hid1, frac1} : {hid0, frac0};
            s1_sml_q     <= swap_d ? {hid0, frac0} : {hid1, frac1};
            s1_exp_q     <= swap_d ? eexp1 : eexp0;
            s1_diff_q    <= diff_d;
            s1_act_s_q   <= act_s_d;
            s1_act_sub_q <= act_sub_d;
            s1_swap_q    <= swap_d;
            s1_rm_q      <= rm;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: alignment shift with sticky collection
    // ------------------------------------------------------------------
    logic [111:0] wide;
    logic         sat_d, sticky;
    logic [55:0]  sml_d;

    // The shifted-out bits land in the low half of the double-width vector.
    assign wide   = {s1_sml_q, 3'b000, 56'd0} >> s1_diff_q[5:0];
    assign sticky = |wide[55:0];
    assign sat_d  = (s1_diff_q >= SAT_AMT);
    assign sml_d  = sat_d ? {55'd0, |s1_sml_q}
                          : {wide[111:57], wide[56] | sticky};

    // Output registers load on stage-1 advance and hold otherwise.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            out_big_mant  <= '0;
            out_sml_mant  <= '0;
            out_exp       <= '0;
            out_act_s     <= 1'b0;
            out_act_sub   <= 1'b0;
            out_swap      <= 1'b0;
            out_shift_sat <= 1'b0;
            out_rm        <= '0;
        end else if (s1_adv) begin
            out_big_mant  <= {s1_big_q, 3'b000};
            out_sml_mant  <= sml_d;
            out_exp       <= s1_exp_q;
            out_act_s     <= s1_act_s_q;
            out_act_sub   <= s1_act_sub_q;
            out_swap      <= s1_swap_q;
            out_shift_sat <= sat_d;
            out_rm        <= s1_rm_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aq_fadd_double_align.sv
// ============================================================================
//  Module   : tb_aq_fadd_double_align
//  Purpose  : Self-checking bench for aq_fadd_double_align: directed vector
//             table, handshake/flush/reset sequences and randomized traffic
//             scored against a behavioural model.
//  Options  : honours AQ_FADD_ALIGN_DENORM_EN for the denormal vector/model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aq_fadd_double_align;

    typedef struct {
        logic        s0;
        logic [10:0] e0;
        logic [51:0] f0;
        logic        s1;
        logic [10:0] e1;
        logic [51:0] f1;
        logic        sub;
        logic [2:0]  rm;
    } op_t;

    typedef struct packed {
        logic [55:0] big;
        logic [55:0] sml;
        logic [10:0] exp;
        logic        act_s;
        logic        act_sub;
        logic        swap;
        logic        sat;
        logic [2:0]  rm;
    } res_t;

    typedef struct {
        op_t  op;
        res_t res;
    } vec_t;

    logic        clk, rst_n, pipe_flush, in_vld, in_rdy, out_vld, out_rdy;
    logic        src0_sign, src1_sign, op_sub;
    logic [10:0] src0_exp, src1_exp, out_exp;
    logic [51:0] src0_frac, src1_frac;
    logic [2:0]  rm, out_rm;
    logic [55:0] out_big_mant, out_sml_mant;
    logic        out_act_s, out_act_sub, out_swap, out_shift_sat;
    res_t        dut_res;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    res_t sbq[$];

    aq_fadd_double_align #(.SHIFT_SAT(56)) dut (
        .forever_cpuclk(clk),
        .cpurst_b      (rst_n),
        .pipe_flush    (pipe_flush),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .src0_sign     (src0_sign),
        .src0_exp      (src0_exp),
        .src0_frac     (src0_frac),
        .src1_sign     (src1_sign),
        .src1_exp      (src1_exp),
        .src1_frac     (src1_frac),
        .op_sub        (op_sub),
        .rm            (rm),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .out_big_mant  (out_big_mant),
        .out_sml_mant  (out_sml_mant),
        .out_exp       (out_exp),
        .out_act_s     (out_act_s),
        .out_act_sub   (out_act_sub),
        .out_swap      (out_swap),
        .out_shift_sat (out_shift_sat),
        .out_rm        (out_rm)
    );

    assign dut_res = {out_big_mant, out_sml_mant, out_exp, out_act_s,
                      out_act_sub, out_swap, out_shift_sat, out_rm};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [129:0] act, input logic [129:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Behavioural reference: alignment computed with plain integer arithmetic.
    function automatic res_t ref_model(input op_t o);
        res_t        r;
        logic [51:0] fa, fb;
        logic [63:0] sig0, sig1, bsig, ssig, ext, sh;
        int          ea, eb, d;
        logic        esb, swp;
        fa = o.f0;
        fb = o.f1;
`ifndef AQ_FADD_ALIGN_DENORM_EN
        if (o.e0 == 11'd0) fa = '0;
        if (o.e1 == 11'd0) fb = '0;
`endif
        ea   = (o.e0 == 11'd0) ? 1 : int'(o.e0);
        eb   = (o.e1 == 11'd0) ? 1 : int'(o.e1);
        sig0 = {11'd0, o.e0 != 11'd0, fa};
        sig1 = {11'd0, o.e1 != 11'd0, fb};
        esb  = o.s1 ^ o.sub;
        swp  = (eb > ea) || (eb == ea && fb > fa);
        d    = swp ? eb - ea : ea - eb;
        bsig = swp ? sig1 : sig0;
        ssig = swp ? sig0 : sig1;
        r.big = 56'(bsig * 8);
        if (d >= 56) begin
            r.sml = 56'(ssig != 0);
        end else begin
            ext   = ssig * 8;
            sh    = ext >> d;
            r.sml = 56'(sh | 64'((sh << d) != ext));
        end
        r.exp     = 11'(swp ? eb : ea);
        r.act_s   = swp ? esb : o.s0;
        r.act_sub = o.s0 ^ esb;
        r.swap    = swp;
        r.sat     = (d >= 56);
        r.rm      = o.rm;
        return r;
    endfunction

    function automatic vec_t V(input logic s0, input logic [10:0] e0, input logic [51:0] f0,
                               input logic s1, input logic [10:0] e1, input logic [51:0] f1,
                               input logic sub, input logic [2:0] r,
                               input logic [55:0] big, input logic [55:0] sml,
                               input logic [10:0] ex, input logic as, input logic asub,
                               input logic sw, input logic sat);
        vec_t v;
        v.op  = '{s0: s0, e0: e0, f0: f0, s1: s1, e1: e1, f1: f1, sub: sub, rm: r};
        v.res = '{big: big, sml: sml, exp: ex, act_s: as, act_sub: asub,
                  swap: sw, sat: sat, rm: r};
        return v;
    endfunction

    task automatic apply(input op_t o);
        src0_sign = o.s0; src0_exp = o.e0; src0_frac = o.f0;
        src1_sign = o.s1; src1_exp = o.e1; src1_frac = o.f1;
        op_sub    = o.sub; rm = o.rm;
    endtask

    // Offer one operand pair and hold it until accepted (bounded).
    task automatic send(input op_t o);
        int cnt;
        apply(o);
        in_vld = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!in_rdy && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_rdy) chk("send_timeout", 130'(in_rdy), 130'(1));
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    function automatic op_t rand_op();
        op_t o;
        logic [63:0] r0, r1;
        int e1i;
        r0 = {$urandom, $urandom};
        r1 = {$urandom, $urandom};
        o.s0  = r0[63];
        o.s1  = r1[63];
        o.sub = $urandom_range(0, 1) == 1;
        o.rm  = 3'($urandom_range(0, 7));
        o.e0  = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 2046));
        e1i   = int'(o.e0) + int'($urandom_range(0, 130)) - 65;
        if (e1i < 0) e1i = 0;
        if (e1i > 2046) e1i = 2046;
        o.e1 = ($urandom_range(0, 9) == 0) ? 11'd0 : 11'(e1i);
        o.f0 = r0[51:0];
        o.f1 = ($urandom_range(0, 7) == 0) ? r0[51:0] : r1[51:0];
        if ($urandom_range(0, 15) == 0) o.e1 = o.e0;
        return o;
    endfunction

    // Scoreboard monitor: compares departing results, holds during stall,
    // and predicts every accepted input with the reference model.
    res_t res_prev;
    logic stall_prev = 1'b0;
    always @(negedge clk) begin
        op_t cur;
        if (!rst_n) begin
            sbq.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("hold_stable", dut_res, res_prev);
            if (out_vld && out_rdy) begin
                n_out++;
                if (sbq.size() == 0) chk("unexpected_output", 130'(out_vld), 130'(0));
                else chk("scoreboard", dut_res, sbq.pop_front());
            end
            if (pipe_flush) begin
                sbq.delete();
            end else if (in_vld && in_rdy) begin
                cur = '{s0: src0_sign, e0: src0_exp, f0: src0_frac, s1: src1_sign,
                        e1: src1_exp, f1: src1_frac, sub: op_sub, rm: rm};
                sbq.push_back(ref_model(cur));
            end
            stall_prev = out_vld && !out_rdy;
            res_prev   = dut_res;
        end
    end

    vec_t vecs[12];

    initial begin
        int lat, nb;
        op_t o;
        rst_n = 1'b0; pipe_flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        apply('{s0: 0, e0: 0, f0: 0, s1: 0, e1: 0, f1: 0, sub: 0, rm: 0});

        vecs[0]  = V(0, 11'h3FF, 52'h0, 0, 11'h3FF, 52'h0, 0, 3'd0,
                     56'h80000000000000, 56'h80000000000000, 11'h3FF, 0, 0, 0, 0);
        vecs[1]  = V(0, 11'h3FF, 52'h0, 0, 11'h401, 52'h8000000000000, 1, 3'd1,
                     56'hC0000000000000, 56'h20000000000000, 11'h401, 1, 1, 1, 0);
        vecs[2]  = V(0, 11'h400, 52'h0, 0, 11'h3A0, 52'h1, 0, 3'd2,
                     56'h80000000000000, 56'h1, 11'h400, 0, 0, 0, 1);
        vecs[3]  = V(0, 11'h436, 52'h0, 0, 11'h400, 52'h0, 0, 3'd3,
                     56'h80000000000000, 56'h2, 11'h436, 0, 0, 0, 0);
        vecs[4]  = V(0, 11'h437, 52'h0, 0, 11'h400, 52'h1, 0, 3'd4,
                     56'h80000000000000, 56'h1, 11'h437, 0, 0, 0, 0);
        vecs[5]  = V(0, 11'h438, 52'h0, 0, 11'h400, 52'h0, 0, 3'd5,
                     56'h80000000000000, 56'h1, 11'h438, 0, 0, 0, 1);
        vecs[6]  = V(0, 11'h3FF, 52'h5, 1, 11'h3FF, 52'h5, 0, 3'd6,
                     56'h80000000000028, 56'h80000000000028, 11'h3FF, 0, 1, 0, 0);
        vecs[7]  = V(0, 11'h3FF, 52'h1, 1, 11'h3FF, 52'h2, 1, 3'd7,
                     56'h80000000000010, 56'h80000000000008, 11'h3FF, 0, 0, 1, 0);
        vecs[8]  = V(1, 11'h0, 52'h0, 0, 11'h0, 52'h0, 0, 3'd0,
                     56'h0, 56'h0, 11'h1, 1, 1, 0, 0);
`ifdef AQ_FADD_ALIGN_DENORM_EN
        vecs[9]  = V(0, 11'h0, 52'h1, 0, 11'h0, 52'h0, 0, 3'd1,
                     56'h8, 56'h0, 11'h1, 0, 0, 0, 0);
`else
        vecs[9]  = V(0, 11'h0, 52'h1, 0, 11'h0, 52'h0, 0, 3'd1,
                     56'h0, 56'h0, 11'h1, 0, 0, 0, 0);
`endif
        vecs[10] = V(0, 11'h0, 52'h0, 0, 11'h3FF, 52'h0, 0, 3'd2,
                     56'h80000000000000, 56'h0, 11'h3FF, 0, 0, 1, 1);
        vecs[11] = V(1, 11'h3FF, 52'h0, 0, 11'h3FF, 52'h0, 1, 3'd3,
                     56'h80000000000000, 56'h80000000000000, 11'h3FF, 1, 0, 0, 0);

        // Reset state.
        #1;
        chk("reset_outputs", dut_res, '0);
        chk("reset_out_vld", 130'(out_vld), 130'(0));
        chk("reset_in_rdy", 130'(in_rdy), 130'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table with latency check.
        foreach (vecs[i]) begin
            send(vecs[i].op);
            lat = 1;
            @(negedge clk);
            while (!out_vld && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("latency_v%0d", i), 130'(lat), 130'(2));
            chk($sformatf("vector_v%0d", i), dut_res, vecs[i].res);
            @(posedge clk);
            #1;
        end

        // Backpressure: third input stalls, outputs hold, all drain in order.
        nb = n_out;
        out_rdy = 1'b0;
        send(rand_op());
        send(rand_op());
        apply(rand_op());
        in_vld = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_rdy_low", 130'(in_rdy), 130'(0));
            chk("bp_out_vld", 130'(out_vld), 130'(1));
            @(posedge clk);
            #1;
        end
        out_rdy = 1'b1;
        @(negedge clk);
        chk("bp_in_rdy_resume", 130'(in_rdy), 130'(1));
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_drain_count", 130'(n_out - nb), 130'(3));
        chk("bp_queue_empty", 130'(sbq.size()), 130'(0));

        // Flush with both stages full and a pending input.
        out_rdy = 1'b0;
        send(rand_op());
        send(rand_op());
        apply(rand_op());
        in_vld = 1'b1;
        pipe_flush = 1'b1;
        @(posedge clk);
        #1;
        pipe_flush = 1'b0;
        in_vld = 1'b0;
        @(negedge clk);
        chk("flush_out_vld", 130'(out_vld), 130'(0));
        chk("flush_in_rdy", 130'(in_rdy), 130'(1));
        nb = n_out;
        out_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_no_output", 130'(n_out - nb), 130'(0));

        // Asynchronous reset mid-stream.
        out_rdy = 1'b0;
        send(rand_op());
        send(rand_op());
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_outputs", dut_res, '0);
        chk("areset_out_vld", 130'(out_vld), 130'(0));
        chk("areset_in_rdy", 130'(in_rdy), 130'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_rdy = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic with backpressure and occasional flush.
        for (int c = 0; c < 2000; c++) begin
            o = rand_op();
            apply(o);
            in_vld     = $urandom_range(0, 3) != 0;
            out_rdy    = $urandom_range(0, 3) != 0;
            pipe_flush = $urandom_range(0, 59) == 0;
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        pipe_flush = 1'b0;
        out_rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("random_drain_empty", 130'(sbq.size()), 130'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
